// File: rtl/pe_accumulator.sv
// Dot-product reduction stage: sums a programmed-length run of signed PE products
// and returns one saturated result per run. Optional macro PE_ACC_SHIFT_EN adds a rounded right shift.
module pe_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 16,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic        [LEN_WIDTH-1:0]  len_i,
`ifdef PE_ACC_SHIFT_EN
  input  logic        [4:0]            shift_i,
`endif
  input  logic                         prod_valid_i,
  output logic                         prod_ready_o,
  input  logic signed [DATA_WIDTH-1:0] prod_data_i,
  output logic                         res_valid_o,
  input  logic                         res_ready_i,
  output logic signed [DATA_WIDTH-1:0] res_data_o,
  output logic                         res_sat_o,
  output logic                         busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH+1-DATA_WIDTH){1'b0}}, 1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH+1-DATA_WIDTH){1'b1}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Returns {clipped, value} for a one-bit-wider-than-accumulator input.
  function automatic logic [DATA_WIDTH:0] saturate(input logic signed [ACC_WIDTH:0] v);
    if (v > SAT_MAX) begin
      return {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
    end else if (v < SAT_MIN) begin
      return {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
    end
    return {1'b0, v[DATA_WIDTH-1:0]};
  endfunction

`ifdef PE_ACC_SHIFT_EN
  // Extra headroom bit keeps the half-up bias from wrapping a near-full accumulator.
  function automatic logic signed [ACC_WIDTH:0] round_shift(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic        [4:0]           sh
  );
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] bias;
    ext  = {a[ACC_WIDTH-1], a};
    bias = '0;
    if (sh != 5'd0) begin
      bias = (ACC_WIDTH+1)'(1) << (sh - 5'd1);
    end
    return (ext + bias) >>> sh;
  endfunction
`endif

  state_t state, state_next;

  logic        [LEN_WIDTH-1:0]  len_p0;
  logic        [LEN_WIDTH-1:0]  count_p0;
  logic signed [ACC_WIDTH-1:0]  acc_p0;
  logic signed [ACC_WIDTH-1:0]  acc_sum;
  logic signed [ACC_WIDTH:0]    scaled;
  logic        [DATA_WIDTH:0]   sat_res;
  logic signed [DATA_WIDTH-1:0] res_data_p1;
  logic                         res_sat_p1;

  logic run_start;
  logic run_empty;
  logic beat;
  logic beat_last;

`ifdef PE_ACC_SHIFT_EN
  logic [4:0] shift_p0;
`endif

  assign beat_last = (count_p0 == (len_p0 - LEN_WIDTH'(1)));
  assign acc_sum   = acc_p0 + ACC_WIDTH'(prod_data_i);

`ifdef PE_ACC_SHIFT_EN
  assign scaled = round_shift(acc_sum, shift_p0);
`else
  assign scaled = {acc_sum[ACC_WIDTH-1], acc_sum};
`endif

  assign sat_res = saturate(scaled);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    prod_ready_o = 1'b0;
    res_valid_o  = 1'b0;
    run_start    = 1'b0;
    run_empty    = 1'b0;
    beat         = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          run_start = 1'b1;
          if (len_i == '0) begin
            run_empty  = 1'b1;
            state_next = OUTPUT;
          end else begin
            state_next = ACCUM;
          end
        end
      end
      ACCUM: begin
        prod_ready_o = 1'b1;
        if (prod_valid_i) begin
          beat = 1'b1;
          if (beat_last) begin
            state_next = OUTPUT;
          end
        end
      end
      OUTPUT: begin
        res_valid_o = 1'b1;
        if (res_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // p0: run setup and accumulation; p1: saturated result captured on the final beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_p0      <= '0;
      count_p0    <= '0;
      acc_p0      <= '0;
      res_data_p1 <= '0;
      res_sat_p1  <= 1'b0;
`ifdef PE_ACC_SHIFT_EN
      shift_p0    <= '0;
`endif
    end else begin
      if (run_start) begin
        len_p0   <= len_i;
        count_p0 <= '0;
        acc_p0   <= '0;
`ifdef PE_ACC_SHIFT_EN
        shift_p0 <= shift_i;
`endif
      end
      if (run_empty) begin
        res_data_p1 <= '0;
        res_sat_p1  <= 1'b0;
      end
      if (beat) begin
        acc_p0   <= acc_sum;
        count_p0 <= count_p0 + LEN_WIDTH'(1);
        if (beat_last) begin
          res_data_p1 <= sat_res[DATA_WIDTH-1:0];
          res_sat_p1  <= sat_res[DATA_WIDTH];
        end
      end
    end
  end

  assign res_data_o = res_data_p1;
  assign res_sat_o  = res_sat_p1;
  assign busy_o     = (state != IDLE);

  a_res_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (res_valid_o && !res_ready_i) |=> (res_valid_o && $stable(res_data_o) && $stable(res_sat_o)));

endmodule

// File: tb/tb_pe_accumulator.sv
// Directed testbench for pe_accumulator; define PE_ACC_SHIFT_EN to also cover the shift option.
module tb_pe_accumulator;

  logic               clk_i;
  logic               rst_ni;
  logic               start_i;
  logic        [15:0] len_i;
`ifdef PE_ACC_SHIFT_EN
  logic        [4:0]  shift_i;
`endif
  logic               prod_valid_i;
  logic               prod_ready_o;
  logic signed [15:0] prod_data_i;
  logic               res_valid_o;
  logic               res_ready_i;
  logic signed [15:0] res_data_o;
  logic               res_sat_o;
  logic               busy_o;

  int passed = 0;
  int total  = 0;

  pe_accumulator dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .start_i      (start_i),
    .len_i        (len_i),
`ifdef PE_ACC_SHIFT_EN
    .shift_i      (shift_i),
`endif
    .prod_valid_i (prod_valid_i),
    .prod_ready_o (prod_ready_o),
    .prod_data_i  (prod_data_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .res_data_o   (res_data_o),
    .res_sat_o    (res_sat_o),
    .busy_o       (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; len_i = '0; prod_valid_i = 1'b0;
    prod_data_i = '0; res_ready_i = 1'b0;
`ifdef PE_ACC_SHIFT_EN
    shift_i = '0;
`endif
    tick(); tick();
    total++;
    if ({busy_o, prod_ready_o, res_valid_o, res_sat_o, res_data_o} !== 20'd0) begin
      $display("FAIL reset_outputs: got busy=%0b rdy=%0b v=%0b s=%0b d=%0d, want all 0",
               busy_o, prod_ready_o, res_valid_o, res_sat_o, res_data_o);
    end else passed++;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    start_i = 1'b1; len_i = 16'd4;
    tick();
    start_i = 1'b0;
    total++;
    if ({busy_o, prod_ready_o, res_valid_o} !== 3'b110) begin
      $display("FAIL basic_enter_accum: got busy=%0b rdy=%0b v=%0b, want 1 1 0",
               busy_o, prod_ready_o, res_valid_o);
    end else passed++;
    prod_valid_i = 1'b1;
    prod_data_i = 16'sd3;   tick();
    prod_data_i = -16'sd5;  tick();
    prod_data_i = 16'sd10;  tick();
    total++;
    if (res_valid_o !== 1'b0) begin
      $display("FAIL basic_early_valid: got v=%0b after 3 of 4, want 0", res_valid_o);
    end else passed++;
    prod_data_i = 16'sd2;   tick();
    prod_valid_i = 1'b0;
    total++;
    if ({res_valid_o, res_sat_o, prod_ready_o} !== 3'b100 || res_data_o !== 16'sd10) begin
      $display("FAIL basic_result: got v=%0b s=%0b rdy=%0b d=%0d, want 1 0 0 d=10",
               res_valid_o, res_sat_o, prod_ready_o, res_data_o);
    end else passed++;
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    total++;
    if ({res_valid_o, busy_o} !== 2'b00) begin
      $display("FAIL basic_return_idle: got v=%0b busy=%0b, want 0 0", res_valid_o, busy_o);
    end else passed++;
  endtask

  task automatic test_saturation();
    start_i = 1'b1; len_i = 16'd3;
    tick();
    start_i = 1'b0;
    prod_valid_i = 1'b1; prod_data_i = 16'sd20000;
    tick(); tick(); tick();
    prod_valid_i = 1'b0;
    total++;
    if (res_valid_o !== 1'b1 || res_sat_o !== 1'b1 || res_data_o !== 16'sd32767) begin
      $display("FAIL sat_positive: got v=%0b s=%0b d=%0d, want 1 1 d=32767",
               res_valid_o, res_sat_o, res_data_o);
    end else passed++;
    res_ready_i = 1'b1; tick(); res_ready_i = 1'b0;

    start_i = 1'b1; len_i = 16'd2;
    tick();
    start_i = 1'b0;
    prod_valid_i = 1'b1; prod_data_i = -16'sd20000;
    tick(); tick();
    prod_valid_i = 1'b0;
    total++;
    if (res_valid_o !== 1'b1 || res_sat_o !== 1'b1 || res_data_o !== -16'sd32768) begin
      $display("FAIL sat_negative: got v=%0b s=%0b d=%0d, want 1 1 d=-32768",
               res_valid_o, res_sat_o, res_data_o);
    end else passed++;
    res_ready_i = 1'b1; tick(); res_ready_i = 1'b0;
  endtask

  task automatic test_len_zero();
    prod_valid_i = 1'b1; prod_data_i = 16'sd77;
    total++;
    if (prod_ready_o !== 1'b0) begin
      $display("FAIL idle_no_ready: got rdy=%0b in IDLE, want 0", prod_ready_o);
    end else passed++;
    start_i = 1'b1; len_i = 16'd0;
    tick();
    start_i = 1'b0;
    total++;
    if ({res_valid_o, res_sat_o, prod_ready_o} !== 3'b100 || res_data_o !== 16'sd0) begin
      $display("FAIL len0_result: got v=%0b s=%0b rdy=%0b d=%0d, want 1 0 0 d=0",
               res_valid_o, res_sat_o, prod_ready_o, res_data_o);
    end else passed++;
    res_ready_i = 1'b1; tick(); res_ready_i = 1'b0;
    prod_valid_i = 1'b0;
    total++;
    if ({res_valid_o, busy_o} !== 2'b00) begin
      $display("FAIL len0_idle: got v=%0b busy=%0b, want 0 0", res_valid_o, busy_o);
    end else passed++;
  endtask

  task automatic test_hold();
    int stable_bad;
    stable_bad = 0;
    start_i = 1'b1; len_i = 16'd2;
    tick();
    start_i = 1'b0;
    prod_valid_i = 1'b1;
    prod_data_i = 16'sd100; tick();
    prod_data_i = 16'sd200; tick();
    prod_valid_i = 1'b0;
    start_i = 1'b1; len_i = 16'd5;
    for (int i = 0; i < 5; i++) begin
      if (res_valid_o !== 1'b1 || res_data_o !== 16'sd300 || res_sat_o !== 1'b0 ||
          prod_ready_o !== 1'b0)
        stable_bad++;
      tick();
    end
    total++;
    if (stable_bad != 0) begin
      $display("FAIL hold_stable: got %0d bad cycles (last v=%0b d=%0d rdy=%0b), want 0 with d=300",
               stable_bad, res_valid_o, res_data_o, prod_ready_o);
    end else passed++;
    res_ready_i = 1'b1;
    tick();
    start_i = 1'b0; res_ready_i = 1'b0;
    total++;
    if ({busy_o, res_valid_o, prod_ready_o} !== 3'b000) begin
      $display("FAIL hold_start_ignored: got busy=%0b v=%0b rdy=%0b, want 0 0 0",
               busy_o, res_valid_o, prod_ready_o);
    end else passed++;
    tick();
    total++;
    if (busy_o !== 1'b0) begin
      $display("FAIL hold_stays_idle: got busy=%0b, want 0", busy_o);
    end else passed++;
  endtask

  task automatic test_gaps();
    int gap_bad;
    gap_bad = 0;
    start_i = 1'b1; len_i = 16'd3;
    tick();
    start_i = 1'b0;
    prod_valid_i = 1'b1; prod_data_i = 16'sd7; tick();
    prod_valid_i = 1'b0; prod_data_i = 16'sd999;
    for (int i = 0; i < 2; i++) begin
      if (prod_ready_o !== 1'b1 || busy_o !== 1'b1 || res_valid_o !== 1'b0) gap_bad++;
      tick();
    end
    prod_valid_i = 1'b1; prod_data_i = -16'sd2; tick();
    prod_valid_i = 1'b0; prod_data_i = 16'sd999;
    for (int i = 0; i < 2; i++) begin
      if (prod_ready_o !== 1'b1 || res_valid_o !== 1'b0) gap_bad++;
      tick();
    end
    prod_valid_i = 1'b1; prod_data_i = 16'sd40; tick();
    prod_valid_i = 1'b0;
    total++;
    if (gap_bad != 0) begin
      $display("FAIL gaps_hold: got %0d bad gap cycles, want 0", gap_bad);
    end else passed++;
    total++;
    if (res_valid_o !== 1'b1 || res_sat_o !== 1'b0 || res_data_o !== 16'sd45) begin
      $display("FAIL gaps_result: got v=%0b s=%0b d=%0d, want 1 0 d=45",
               res_valid_o, res_sat_o, res_data_o);
    end else passed++;
    res_ready_i = 1'b1; tick(); res_ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    start_i = 1'b1; len_i = 16'd4;
    tick();
    start_i = 1'b0;
    prod_valid_i = 1'b1;
    prod_data_i = 16'sd1000; tick();
    prod_data_i = 16'sd2000; tick();
    prod_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    total++;
    if ({busy_o, prod_ready_o, res_valid_o, res_sat_o, res_data_o} !== 20'd0) begin
      $display("FAIL midrun_reset: got busy=%0b rdy=%0b v=%0b s=%0b d=%0d, want all 0",
               busy_o, prod_ready_o, res_valid_o, res_sat_o, res_data_o);
    end else passed++;
    tick();
    rst_ni = 1'b1;
    tick();
    start_i = 1'b1; len_i = 16'd2;
    tick();
    start_i = 1'b0;
    prod_valid_i = 1'b1;
    prod_data_i = 16'sd5; tick();
    prod_data_i = 16'sd6; tick();
    prod_valid_i = 1'b0;
    total++;
    if (res_valid_o !== 1'b1 || res_data_o !== 16'sd11) begin
      $display("FAIL midrun_fresh_sum: got v=%0b d=%0d, want 1 d=11", res_valid_o, res_data_o);
    end else passed++;
    res_ready_i = 1'b1; tick(); res_ready_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    start_i = 1'b1; len_i = 16'd1;
    tick();
    start_i = 1'b0;
    prod_valid_i = 1'b1; prod_data_i = -16'sd7; tick();
    prod_valid_i = 1'b0;
    res_ready_i = 1'b1;
    total++;
    if (res_valid_o !== 1'b1 || res_data_o !== -16'sd7) begin
      $display("FAIL b2b_first: got v=%0b d=%0d, want 1 d=-7", res_valid_o, res_data_o);
    end else passed++;
    tick();
    res_ready_i = 1'b0;
    start_i = 1'b1; len_i = 16'd1;
    tick();
    start_i = 1'b0;
    prod_valid_i = 1'b1; prod_data_i = 16'sd9; tick();
    prod_valid_i = 1'b0;
    total++;
    if (res_valid_o !== 1'b1 || res_data_o !== 16'sd9) begin
      $display("FAIL b2b_second: got v=%0b d=%0d, want 1 d=9", res_valid_o, res_data_o);
    end else passed++;
    res_ready_i = 1'b1; tick(); res_ready_i = 1'b0;
  endtask

`ifdef PE_ACC_SHIFT_EN
  task automatic test_shift();
    logic signed [15:0] exp_vals [3];
    logic signed [15:0] a_vals   [3];
    logic        [4:0]  sh_vals  [3];
    exp_vals = '{16'sd13, -16'sd12, 16'sd100};
    a_vals   = '{16'sd60, -16'sd60, 16'sd60};
    sh_vals  = '{5'd3, 5'd3, 5'd0};
    for (int k = 0; k < 3; k++) begin
      start_i = 1'b1; len_i = 16'd2; shift_i = sh_vals[k];
      tick();
      start_i = 1'b0; shift_i = 5'd31;
      prod_valid_i = 1'b1;
      prod_data_i = a_vals[k]; tick();
      prod_data_i = (a_vals[k] < 0) ? -16'sd40 : 16'sd40; tick();
      prod_valid_i = 1'b0;
      total++;
      if (res_valid_o !== 1'b1 || res_sat_o !== 1'b0 || res_data_o !== exp_vals[k]) begin
        $display("FAIL shift_case%0d: got v=%0b s=%0b d=%0d, want 1 0 d=%0d",
                 k, res_valid_o, res_sat_o, res_data_o, exp_vals[k]);
      end else passed++;
      res_ready_i = 1'b1; tick(); res_ready_i = 1'b0;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_len_zero();
    test_hold();
    test_gaps();
    test_reset_mid_run();
    test_back_to_back();
`ifdef PE_ACC_SHIFT_EN
    test_shift();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pe_accumulator.md
Name: pe_accumulator

Overview:
- Downstream stage of the PE multiplier; consumes its truncated signed DATA_WIDTH products one at a time.
- Sums a programmed-length run of products (dot-product reduction) into a wide signed accumulator.
- Returns one saturated DATA_WIDTH result per run over a valid/ready handshake, toward writeback/result buffering.

Parameters:
- DATA_WIDTH, nmcu_pkg::DATA_WIDTH (16), width of incoming products and outgoing result (signed).
- LEN_WIDTH, 16, width of the run-length field.
- ACC_WIDTH, 32, internal accumulator width; must be >= DATA_WIDTH+LEN_WIDTH, so no internal overflow is possible.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- start_i  in  1  begin a run; sampled only in IDLE.
- len_i  in  LEN_WIDTH  number of products in the run (unsigned); sampled with start_i.
- prod_valid_i  in  1  product available.
- prod_ready_o  out  1  accumulator accepts a product.
- prod_data_i  in  DATA_WIDTH  signed product from the PE.
- res_valid_o  out  1  result available.
- res_ready_i  in  1  consumer accepts result.
- res_data_o  out  DATA_WIDTH  signed saturated sum.
- res_sat_o  out  1  result was clipped; valid with res_valid_o.
- busy_o  out  1  high in ACCUM or OUTPUT.

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, acc=0, count=0; all outputs 0. Assertion mid-run aborts the run; no partial result is emitted.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE: prod_ready_o=0, res_valid_o=0.
  - start_i=1 with len_i>0 -> latch len, acc=0, count=0, go to ACCUM.
  - start_i=1 with len_i=0 -> acc=0, go to OUTPUT (result 0, sat 0).
- ACCUM: prod_ready_o=1.
  - On prod_valid_i && prod_ready_o: acc += sign-extend(prod_data_i) to ACC_WIDTH; count++.
  - If that handshake is number len (count==len-1 before increment) -> go to OUTPUT.
  - Gaps in prod_valid_i are allowed; acc and count hold.
- OUTPUT: prod_ready_o=0; res_valid_o=1.
  - res_data_o = acc clipped to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - res_sat_o=1 iff clipping occurred.
  - res_data_o and res_sat_o are registered and held stable while res_ready_i=0.
  - On res_ready_i=1 -> IDLE (res_valid_o drops next cycle).
- Latency: res_valid_o rises the cycle after the final product handshake, or the cycle after start_i when len=0.
- Throughput: one product per cycle in ACCUM. Minimum per-run overhead is 1 start cycle plus 1 output cycle.
- start_i outside IDLE is ignored (no queuing). start_i in the same cycle as the OUTPUT->IDLE transition is also ignored; it must be reasserted in IDLE.
- prod_data_i and prod_valid_i outside ACCUM are ignored.
- busy_o = (state != IDLE).

Optional Feature:
- Macro: PE_ACC_SHIFT_EN.
- Defined:
  - Adds input port shift_i (5 bits), sampled with start_i and held for the run.
  - Before saturation, acc is arithmetically right-shifted by shift; round half up by adding 2^(shift-1) when shift>0.
  - res_sat_o reflects clipping of the shifted value.
- Undefined: no shift_i port; shift is fixed at 0 and results are bit-identical to shift_i=0.

Test Plan:
- start, len=4; products 3, -5, 10, 2 back-to-back -> res_valid_o=1 one cycle after 4th handshake, res_data_o=10, res_sat_o=0.
- len=3, products 20000 x3 -> res_data_o=32767, sat=1. len=2, products -20000 x2 -> res_data_o=-32768, sat=1.
- start with len=0 -> res_valid_o=1 next cycle, res_data_o=0, sat=0, no product accepted.
- len=2, result presented with res_ready_i=0 for 5 cycles, start_i pulsed meanwhile -> data held stable, prod_ready_o=0, start ignored; IDLE after ready.
- len=3, products separated by 2-cycle valid gaps -> correct sum. Separately, rst_ni low mid-ACCUM -> all outputs 0 immediately, IDLE, next run sums from 0.
- (PE_ACC_SHIFT_EN) shift_i=3, products sum 100 -> res_data_o=13. shift_i=3, sum -100 -> -12. shift_i=0 -> 100.
